// File: rtl/nibble_serial_add_seq_pkg.sv
// Shared state encoding and default geometry for the nibble-serial add sequencer.
package nibble_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int SLICE_W     = 4;
  localparam int SLICE_WORDS = 4;

endpackage

// File: rtl/nibble_serial_add_seq_slice_shift_reg.sv
// W-bit register with parallel load and right shift by one N-bit slice,
// inserting a new slice at the top.
module slice_shift_reg #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [N*WORDS-1:0]   load_val_i,
  input  logic [N-1:0]         ins_i,
  output logic [N*WORDS-1:0]   q_o,
  output logic [N*WORDS-1:0]   next_o
);

  localparam int W = N * WORDS;

  logic [W-1:0] q_q;

  // With a single slice the whole register is replaced by the inserted slice.
  generate
    if (WORDS > 1) begin : g_multi
      assign next_o = {ins_i, q_q[W-1:N]};
    end else begin : g_single
      assign next_o = ins_i;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (shift_i) begin
      q_q <= next_o;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/nibble_serial_add_seq.sv
// Feeds an external combinational N-bit adder slice one slice per cycle, LSB first,
// and reassembles a W-bit result. Optional subtract mode: NIBBLE_SEQ_SUBTRACT_EN.
module nibble_serial_add_seq
  import nibble_seq_pkg::*;
#(
  parameter int N     = SLICE_W,
  parameter int WORDS = SLICE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a_in,
  input  logic [N*WORDS-1:0]   b_in,
  input  logic                 cin,
`ifdef NIBBLE_SEQ_SUBTRACT_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum_out,
  output logic                 cout_out,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_cin,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             sub_q, sub_d;
  logic             sub_req;
  logic             load, shift, run;
  logic [W-1:0]     a_sh, b_sh, res_sh, a_nx, b_nx, res_next;
  logic             unused_sh;

`ifdef NIBBLE_SEQ_SUBTRACT_EN
  assign sub_req = sub;
`else
  assign sub_req = 1'b0;
`endif

  slice_shift_reg #(.N(N), .WORDS(WORDS)) u_op_a (
    .clk(clk), .rst_n(rst_n), .load_i(load), .shift_i(shift),
    .load_val_i(a_in), .ins_i('0), .q_o(a_sh), .next_o(a_nx)
  );

  slice_shift_reg #(.N(N), .WORDS(WORDS)) u_op_b (
    .clk(clk), .rst_n(rst_n), .load_i(load), .shift_i(shift),
    .load_val_i(b_in), .ins_i('0), .q_o(b_sh), .next_o(b_nx)
  );

  slice_shift_reg #(.N(N), .WORDS(WORDS)) u_res (
    .clk(clk), .rst_n(rst_n), .load_i(load), .shift_i(shift),
    .load_val_i('0), .ins_i(add_sum), .q_o(res_sh), .next_o(res_next)
  );

  // Register bits reached only through slicing or the next-value path.
  assign unused_sh = ^{a_sh[W-1:0], b_sh, res_sh, a_nx, b_nx};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          sub_d   = sub_req;
          carry_d = sub_req ? 1'b1 : cin;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        shift   = 1'b1;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_DONE;
          idx_d   = '0;
          sum_d   = res_next;
          cout_d  = add_cout;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
    end
  end

  // Slice operands are zero outside RUN so the shared adder sees a quiet input.
  assign run      = (state_q == S_RUN);
  assign busy     = run;
  assign done     = (state_q == S_DONE);
  assign add_a    = run ? a_sh[N-1:0] : '0;
  assign add_b    = run ? (b_sh[N-1:0] ^ {N{sub_q}}) : '0;
  assign add_cin  = run & carry_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed bench for nibble_serial_add_seq with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy, done, cout_out, add_cin, add_cout;
  logic [15:0] sum_out;
  logic [3:0]  add_a, add_b, add_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_add_seq #(.N(4), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef NIBBLE_SEQ_SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[10];
  int   nvec;
  logic [3:0] cin_seq;
  int   busy_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then follow the operation to its done pulse.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic s, input logic [15:0] es, input logic eco);
    int waited;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    cin_seq  = '0;
    waited   = 0;
    while (!done && waited < 20) begin
      if (busy) begin
        if (busy_cnt < 4) cin_seq[busy_cnt] = add_cin;
        busy_cnt++;
      end
      waited++;
      @(negedge clk);
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("sum_out", {16'b0, sum_out}, {16'b0, es});
    check("cout_out", {31'b0, cout_out}, {31'b0, eco});
    check("busy_cycles", busy_cnt, 32'd4);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    nvec = 0;
    vecs[nvec++] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0};
    vecs[nvec++] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[nvec++] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[nvec++] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[nvec++] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0};
    vecs[nvec++] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
`ifdef NIBBLE_SEQ_SUBTRACT_EN
    vecs[nvec++] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1};
    vecs[nvec++] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0};
    vecs[nvec++] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1};
`endif

    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum", {16'b0, sum_out}, 32'd0);
    check("rst_cout", {31'b0, cout_out}, 32'd0);
    check("rst_add_a", {28'b0, add_a}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].co);
      if (i == 1) check("carry_chain_ffff", {28'b0, cin_seq}, 32'hE);
    end

    // start during RUN with other operands must be ignored; previous result held
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h0FCD; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("held_during_run", {16'b0, sum_out}, {16'b0, vecs[nvec-1].s});
    @(negedge clk);
    a_in = 16'h5555; b_in = 16'h5555; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int dones = 0;
      for (int k = 0; k < 10; k++) begin
        if (done) dones++;
        @(negedge clk);
      end
      check("ignored_start_dones", dones, 32'd1);
    end
    check("ignored_start_sum", {16'b0, sum_out}, 32'h2201);
    check("ignored_start_cout", {31'b0, cout_out}, 32'd0);

    // asynchronous reset while slice 2 is in flight
    a_in = 16'hFFFF; b_in = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_sum", {16'b0, sum_out}, 32'd0);
    check("abort_cout", {31'b0, cout_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dones = 0;
      for (int k = 0; k < 6; k++) begin
        if (done || busy) dones++;
        @(negedge clk);
      end
      check("abort_no_done", dones, 32'd0);
    end
    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_seq.md
Name: nibble_serial_add_seq

Overview:
- Sequencer directly upstream of the N-bit ripple adder slice.
- Accepts wide operands (N*WORDS bits) and feeds the slice one N-bit slice per cycle, LSB slice first.
- Registers the slice carry between cycles and reassembles the slice sums into a wide result.
- Trades latency for area: one adder slice serves arbitrarily wide additions.

Parameters:
- N, 4, width of one adder slice.
- WORDS, 4, number of slices per operation; total width W = N*WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  W  operand A, latched on accepted start.
- b_in  in  W  operand B, latched on accepted start.
- cin  in  1  initial carry-in, latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- sum_out  out  W  result; held until the next completion.
- cout_out  out  1  final carry; held with sum_out.
- add_a  out  N  current A slice to the adder.
- add_b  out  N  current B slice to the adder.
- add_cin  out  1  current carry to the adder.
- add_sum  in  N  slice sum from the adder (combinational).
- add_cout  in  1  slice carry from the adder (combinational).

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state: IDLE. busy=0, done=0, sum_out=0, cout_out=0, all internal registers 0.
  - Reset mid-operation aborts immediately; no done pulse; partial result discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → RUN.
  - Latch a_in/b_in into operand shift registers, carry_q=cin, slice counter idx=0.
  - add_a/add_b/add_cin drive 0.
- RUN:
  - add_a = a_sh[N-1:0], add_b = b_sh[N-1:0], add_cin = carry_q (combinational from registers).
  - Each edge: shift add_sum into the top of the result shift register, then shift right by N.
  - Also each edge: carry_q <= add_cout, operand registers shift right by N, idx++.
  - At edge E_WORDS (idx==WORDS-1): sum_out <= assembled result, cout_out <= add_cout, state → DONE.
- DONE:
  - done=1 for exactly this one cycle, then → IDLE.
- Latency: done is high for the cycle following the WORDS-th edge after the start edge. Back-to-back throughput is one op per WORDS+2 cycles.
- busy=1 only in RUN.
- start in RUN or DONE is ignored; it is not queued.
- sum_out/cout_out change only on completion; the previous result stays stable throughout RUN.
- Width rules:
  - Carry out of slice k is the carry into slice k+1. No intermediate truncation.
  - Result is modulo 2^W; overflow is reported only via cout_out.
  - idx is $clog2(WORDS) bits minimum; WORDS=1 is legal (RUN lasts one cycle).
- The adder slice is purely combinational; no adder latency is tolerated.

Optional Feature:
- Macro: NIBBLE_SEQ_SUBTRACT_EN.
- Defined:
  - Adds input port sub (1 bit), latched with start.
  - sub=1: add_b = ~b_sh[N-1:0] every RUN cycle, and the initial carry_q=1 (cin ignored). Result = A-B mod 2^W; cout_out=1 means no borrow (A>=B unsigned).
  - sub=0: behaves exactly as pure addition.
- Undefined: no sub port; addition only; identical timing.

Decomposition:
- Package nibble_seq_pkg: state enum (IDLE, RUN, DONE) and default constants SLICE_W=4, SLICE_WORDS=4.
- One natural sub-module, slice_shift_reg (W-bit, parallel load, shift right by N with N-bit insert at top).
  - Instantiated three times: operand A, operand B, result.
- Adder slice stays external, wired by the enclosing top.

Test Plan (N=4, WORDS=4, adder slice connected):
- A=0x1234, B=0x0FCD, cin=0, start pulse → done after 4 edges, sum_out=0x2201, cout_out=0; busy high exactly 4 cycles.
- A=0xFFFF, B=0x0001, cin=0 → sum_out=0x0000, cout_out=1; intermediate add_cin=1 on slices 1-3.
- A=0x0000, B=0x0000, cin=1 → sum_out=0x0001, cout_out=0.
- start re-asserted during RUN with different operands → ignored; first result unchanged; single done pulse.
- rst_n low for one cycle during slice 2 → outputs 0, state IDLE, no done; a new start afterwards computes correctly.
- With NIBBLE_SEQ_SUBTRACT_EN:
  - 0x1000-0x0001 → 0x0FFF, cout_out=1.
  - 0x0000-0x0001 → 0xFFFF, cout_out=0.
